// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the seq_mul iterative multiplier.
package seq_mul_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // Iteration counter width for a given operand width; the counter reaches WIDTH.
   function automatic int unsigned cnt_w(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_mul_cneg.sv
// Conditional two's-complement negator: y = neg ? -x : x.
module seq_mul_cneg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic             neg,
   output logic [WIDTH-1:0] y
);

   assign y = neg ? ('0 - x) : x;

endmodule

// File: rtl/seq_mul.sv
// Iterative radix-2 shift-add multiplier with valid/ready on operands and product.
// One operation in flight; WIDTH iterations per product.
// Optional signed mode is enabled by defining SEQ_MUL_SIGNED_EN (adds the is_signed port).
module seq_mul
   import seq_mul_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MUL_SIGNED_EN
   input  logic               is_signed,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p
);

   localparam int unsigned CNT_W = cnt_w(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH:0]     acc_q, acc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [2*WIDTH-1:0] p_q, p_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod_raw, prod_fix;

   // Add step of the current iteration; acc's top bit is always clear before the add.
   assign sum      = mplier_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
   // Full product as it stands after the shift of the current iteration.
   assign prod_raw = {sum, mplier_q[WIDTH-1:1]};

`ifdef SEQ_MUL_SIGNED_EN
   logic neg_q, neg_d;
   logic neg_in;

   assign neg_in = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

   seq_mul_cneg #(.WIDTH(WIDTH)) u_cneg_a (
      .x   (a),
      .neg (is_signed & a[WIDTH-1]),
      .y   (a_mag)
   );

   seq_mul_cneg #(.WIDTH(WIDTH)) u_cneg_b (
      .x   (b),
      .neg (is_signed & b[WIDTH-1]),
      .y   (b_mag)
   );

   seq_mul_cneg #(.WIDTH(2*WIDTH)) u_cneg_p (
      .x   (prod_raw),
      .neg (neg_q),
      .y   (prod_fix)
   );

   // Sign of the pending result, captured with the operands.
   always_ff @(posedge clk) begin
      if (rst) neg_q <= 1'b0;
      else     neg_q <= neg_d;
   end

   // Sign flag next state: only loaded on acceptance.
   always_comb begin
      neg_d = neg_q;
      if (state_q == StIdle && in_valid) neg_d = neg_in;
   end
`else
   assign a_mag    = a;
   assign b_mag    = b;
   assign prod_fix = prod_raw;
`endif

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         p_q      <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         p_q      <= p_d;
      end
   end

   // Next-state and datapath update: accept in IDLE, one shift-add per RUN cycle.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      count_d  = count_q;
      p_d      = p_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               mcand_d  = a_mag;
               mplier_d = b_mag;
               acc_d    = '0;
               count_d  = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            acc_d    = {1'b0, sum[WIDTH:1]};
            mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
            count_d  = count_q + CNT_W'(1);
            // Final iteration: the product is complete, so publish it directly.
            if (count_q == CNT_W'(WIDTH - 1)) begin
               p_d     = prod_fix;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Handshake outputs are masked during reset so nothing is exchanged in that cycle.
   always_comb begin
      in_ready  = (state_q == StIdle) && !rst;
      out_valid = (state_q == StDone) && !rst;
      p         = p_q;
   end

endmodule

// File: tb/tb_seq_mul.sv
// Directed self-checking bench for seq_mul at WIDTH=8, plus an exhaustive WIDTH=3 sweep.
module tb_seq_mul;

`ifdef SEQ_MUL_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, s;
   logic [7:0]  a, b;
   logic [15:0] p;

   logic        in_valid3, in_ready3, out_valid3, out_ready3, s3;
   logic [2:0]  a3, b3;
   logic [5:0]  p3;

   int n_cmp = 0;
   int n_err = 0;

   seq_mul #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
`ifdef SEQ_MUL_SIGNED_EN
      .is_signed (s),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p)
   );

   seq_mul #(.WIDTH(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .a         (a3),
      .b         (b3),
`ifdef SEQ_MUL_SIGNED_EN
      .is_signed (s3),
`endif
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .p         (p3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Golden model: w-bit operands, 2w-bit result.
   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input bit sg, input int w);
      longint xv, yv, pr;
      logic [63:0] m;
      xv = longint'(x);
      yv = longint'(y);
      if (sg && x[w-1]) xv = xv - (longint'(1) << w);
      if (sg && y[w-1]) yv = yv - (longint'(1) << w);
      pr = xv * yv;
      m  = (64'd1 << (2 * w)) - 64'd1;
      return 64'(pr) & m;
   endfunction

   // Issue one op from IDLE and wait for out_valid; lat counts cycles from the accept cycle.
   task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit sg,
                         output int lat, output bit ir_bad);
      a = x; b = y; s = sg; in_valid = 1'b1;
      ir_bad = !in_ready;
      step();
      in_valid = 1'b0;
      a = ~x; b = ~y; s = ~sg;
      lat = 1;
      while (!out_valid && lat < 40) begin
         if (in_ready) ir_bad = 1'b1;
         step();
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd5; s = 1'b0; out_ready = 1'b0;
      in_valid3 = 1'b0; out_ready3 = 1'b0; a3 = '0; b3 = '0; s3 = 1'b0;
      step();
      step();
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if (p !== 16'h0000) begin
         n_err++; $display("FAIL reset_p: got %h want 0000", p);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready_high: got %b want 1", in_ready);
      end
      step();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_no_accept: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_unsigned();
      logic [7:0]  va[6] = '{8'd255, 8'd0, 8'd1,   8'd200, 8'd128, 8'd13};
      logic [7:0]  vb[6] = '{8'd255, 8'd0, 8'd255, 8'd3,   8'd128, 8'd11};
      logic [15:0] ve[6] = '{16'hFE01, 16'h0000, 16'h00FF, 16'h0258, 16'h4000, 16'h008F};
      int lat;
      bit ir_bad;
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], 1'b0, lat, ir_bad);
         n_cmp++;
         if (lat !== 9) begin
            n_err++; $display("FAIL unsigned_latency[%0d]: got %0d want 9", i, lat);
         end
         n_cmp++;
         if (p !== ve[i]) begin
            n_err++; $display("FAIL unsigned_p[%0d]: got %h want %h", i, p, ve[i]);
         end
         n_cmp++;
         if (ir_bad) begin
            n_err++; $display("FAIL unsigned_in_ready[%0d]: got high during op want low", i);
         end
         consume();
      end
   endtask

`ifdef SEQ_MUL_SIGNED_EN
   task automatic test_signed();
      logic [7:0]  va[6] = '{8'h80, 8'hFD, 8'h00, 8'h7F, 8'hFF, 8'hFF};
      logic [7:0]  vb[6] = '{8'h80, 8'h05, 8'h80, 8'h80, 8'hFF, 8'h01};
      logic [15:0] ve[6] = '{16'h4000, 16'hFFF1, 16'h0000, 16'hC080, 16'h0001, 16'hFFFF};
      int lat;
      bit ir_bad;
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], 1'b1, lat, ir_bad);
         n_cmp++;
         if (lat !== 9) begin
            n_err++; $display("FAIL signed_latency[%0d]: got %0d want 9", i, lat);
         end
         n_cmp++;
         if (p !== ve[i]) begin
            n_err++; $display("FAIL signed_p[%0d]: got %h want %h", i, p, ve[i]);
         end
         consume();
      end
   endtask
`endif

   task automatic test_backpressure();
      int lat;
      bit ir_bad;
      run_op(8'd12, 8'd13, 1'b0, lat, ir_bad);
      n_cmp++;
      if (p !== 16'h009C) begin
         n_err++; $display("FAIL bp_p: got %h want 009c", p);
      end
      in_valid = 1'b1; a = 8'd1; b = 8'd1;
      for (int i = 0; i < 20; i++) begin
         step();
         n_cmp++;
         if ({out_valid, in_ready, p} !== {1'b1, 1'b0, 16'h009C}) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: out_valid %b in_ready %b p %h want 1 0 009c",
                     i, out_valid, in_ready, p);
         end
      end
      in_valid = 1'b0;
      consume();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      bit ir_bad;
      bit seen;
      a = 8'd200; b = 8'd200; s = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({in_ready, out_valid, p} !== {1'b1, 1'b0, 16'h0000}) begin
         n_err++;
         $display("FAIL midrun_reset: in_ready %b out_valid %b p %h want 1 0 0000",
                  in_ready, out_valid, p);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_err++; $display("FAIL midrun_no_valid: got out_valid after reset want none");
      end
      run_op(8'd3, 8'd7, 1'b0, lat, ir_bad);
      n_cmp++;
      if (lat !== 9 || p !== 16'd21) begin
         n_err++; $display("FAIL midrun_fresh: latency %0d p %0d want 9 21", lat, p);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      localparam int N = 8;
      logic [15:0] exp_q[$];
      logic [15:0] pv, ev;
      int cyc, idx, got, last;
      bit acc_now, cons_now;
      cyc = 0; idx = 0; got = 0; last = -1;
      a = 8'($urandom); b = 8'($urandom); s = SGN ? 1'($urandom) : 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      while (got < N && cyc < 400) begin
         acc_now  = in_ready && in_valid;
         cons_now = out_valid && out_ready;
         pv       = p;
         if (acc_now) exp_q.push_back(16'(ref_mul(32'(a), 32'(b), s, 8)));
         step();
         cyc++;
         if (acc_now) begin
            idx++;
            if (idx < N) begin
               a = 8'($urandom); b = 8'($urandom); s = SGN ? 1'($urandom) : 1'b0;
            end else begin
               in_valid = 1'b0;
            end
         end
         if (cons_now) begin
            ev = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            n_cmp++;
            if (pv !== ev) begin
               n_err++; $display("FAIL b2b_p[%0d]: got %h want %h", got, pv, ev);
            end
            if (last >= 0) begin
               n_cmp++;
               if (cyc - last !== 10) begin
                  n_err++; $display("FAIL b2b_interval[%0d]: got %0d want 10", got, cyc - last);
               end
            end
            last = cyc;
            got++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      n_cmp++;
      if (got !== N) begin
         n_err++; $display("FAIL b2b_count: got %0d results want %0d", got, N);
      end
   endtask

   task automatic test_width3();
      logic [5:0] ev;
      int lat;
      for (int sg = 0; sg <= int'(SGN); sg++) begin
         for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
               a3 = 3'(x); b3 = 3'(y); s3 = 1'(sg); in_valid3 = 1'b1;
               ev = 6'(ref_mul(32'(x), 32'(y), sg != 0, 3));
               step();
               in_valid3 = 1'b0;
               lat = 1;
               while (!out_valid3 && lat < 20) begin
                  step();
                  lat++;
               end
               n_cmp++;
               if (lat !== 4 || p3 !== ev) begin
                  n_err++;
                  $display("FAIL w3[s%0d %0d*%0d]: latency %0d p %h want 4 %h",
                           sg, x, y, lat, p3, ev);
               end
               out_ready3 = 1'b1;
               step();
               out_ready3 = 1'b0;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
`ifdef SEQ_MUL_SIGNED_EN
      test_signed();
`endif
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      test_width3();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
